// File: rtl/dsp_pkg.sv
// Shared DSP types and helpers.
// Used by the delay line and sibling audio blocks.
package dsp_pkg;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    RD_A,
    RD_B,
    MUL,
    WB
  } fdl_state_e;

  typedef logic signed [63:0] wide_t;

  function automatic wide_t sat_s(input wide_t value, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/del_ram.sv
// Single-port sample buffer, registered read.
// One access per cycle; read data appears one clock later.
module del_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int BUFR_DEPTH = 1024,
  localparam int ADDR_W = $clog2(BUFR_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [BUFR_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/frac_del_line.sv
// Fractional delay line: interpolated tap with saturating feedback.
// One sample per five clocks: IDLE, RD_A, RD_B, MUL, WB.
module frac_del_line
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUFR_DEPTH = 1024,
  parameter int FRAC_WIDTH = 8,
  parameter int FB_WIDTH   = 8,
  localparam int ADDR_W = $clog2(BUFR_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DATA_WIDTH-1:0]   data_i,
  input  logic                           vld_i,
  output logic                           rdy_o,
  input  logic [ADDR_W+FRAC_WIDTH-1:0]   del_i,
  input  logic signed [FB_WIDTH-1:0]     fb_i,
  output logic signed [DATA_WIDTH-1:0]   data_o,
  output logic                           vld_o
);

  fdl_state_e state;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] dly;
  logic [ADDR_W-1:0] d_raw;
  logic [ADDR_W-1:0] dly_in;
  logic [ADDR_W-1:0] addr;
  logic [FRAC_WIDTH-1:0] frac;
  logic signed [FB_WIDTH-1:0] gain;
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] a;
  logic signed [DATA_WIDTH-1:0] q;
  logic signed [DATA_WIDTH-1:0] wdata;
  logic signed [DATA_WIDTH+1:0] y;
  logic we;

  wide_t diff;
  wide_t prod;
  wide_t y_n;
  wide_t fbp;
  wide_t w_n;

  assign rdy_o = (state == IDLE) && !rst;
  assign d_raw = del_i[ADDR_W+FRAC_WIDTH-1:FRAC_WIDTH];

  // Keep the b tap (D+1 back) from ever landing on wr_ptr.
  always_comb begin
    dly_in = d_raw;
    if (d_raw == '0)
      dly_in = ADDR_W'(1);
    else if (d_raw > ADDR_W'(BUFR_DEPTH - 2))
      dly_in = ADDR_W'(BUFR_DEPTH - 2);
  end

  always_comb begin
    diff = wide_t'(q) - wide_t'(a);
    prod = diff * wide_t'({1'b0, frac});
    y_n  = wide_t'(a) + (prod >>> FRAC_WIDTH);
    fbp  = wide_t'(y) * wide_t'(gain);
    w_n  = sat_s(wide_t'(x) + (fbp >>> (FB_WIDTH - 1)), DATA_WIDTH);
  end

  always_comb begin
    we    = 1'b0;
    addr  = wr_ptr;
    wdata = '0;
    unique case (state)
      CLR: begin
        we   = 1'b1;
        addr = clr_ptr;
      end
      RD_A: addr = wr_ptr - dly;
      RD_B: addr = wr_ptr - dly - ADDR_W'(1);
      WB: begin
        we    = 1'b1;
        wdata = DATA_WIDTH'(w_n);
      end
      default: ;
    endcase
  end

  del_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUFR_DEPTH(BUFR_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(q)
  );

  always_ff @(posedge clk) begin
    vld_o <= 1'b0;
    if (rst) begin
      state   <= CLR;
      wr_ptr  <= '0;
      clr_ptr <= '0;
      data_o  <= '0;
    end else begin
      unique case (state)
        CLR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == ADDR_W'(BUFR_DEPTH - 1)) state <= IDLE;
        end
        IDLE: begin
          if (vld_i) begin
            x     <= data_i;
            dly   <= dly_in;
            frac  <= del_i[FRAC_WIDTH-1:0];
            gain  <= fb_i;
            state <= RD_A;
          end
        end
        RD_A: state <= RD_B;
        RD_B: begin
          a     <= q;
          state <= MUL;
        end
        MUL: begin
          y     <= (DATA_WIDTH + 2)'(y_n);
          state <= WB;
        end
        WB: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          data_o <= DATA_WIDTH'(sat_s(wide_t'(y), DATA_WIDTH));
          vld_o  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= CLR;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_del_line.sv
// Directed bench for frac_del_line.
// Scenario tasks each check their own results.
module tb_frac_del_line;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] data_i;
  logic vld_i;
  logic rdy_o;
  logic [17:0] del_i;
  logic signed [7:0] fb_i;
  logic signed [15:0] data_o;
  logic vld_o;

  int n_cmp = 0;
  int n_bad = 0;
  int hist[$];

  always #5 clk = ~clk;

  frac_del_line dut (
    .clk   (clk),
    .rst   (rst),
    .data_i(data_i),
    .vld_i (vld_i),
    .rdy_o (rdy_o),
    .del_i (del_i),
    .fb_i  (fb_i),
    .data_o(data_o),
    .vld_o (vld_o)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    int k;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    k = 0;
    while (!rdy_o && k < 1100) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (!rdy_o) begin
      n_bad++;
      $display("FAIL reset_timeout rdy=%0b required=1", rdy_o);
    end
  endtask

  task automatic send(input int data, input int dl, input int fb,
                      output int y, output int lat);
    int k;
    k = 0;
    while (!rdy_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    data_i = 16'(data);
    del_i  = 18'(dl);
    fb_i   = 8'(fb);
    vld_i  = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
    lat = -1;
    y = 0;
    k = 0;
    while (lat < 0 && k < 8) begin
      @(posedge clk); #1;
      k++;
      if (vld_o) begin
        lat = k;
        y = int'(data_o);
      end
    end
  endtask

  function automatic int model(input int xin, input int dl, input int fb);
    int dd, ff, n, xa, xb, yv, wv;
    dd = dl >> 8;
    if (dd < 1) dd = 1;
    if (dd > 1022) dd = 1022;
    ff = dl & 255;
    n = hist.size();
    xa = (n - dd >= 0) ? hist[n - dd] : 0;
    xb = (n - dd - 1 >= 0) ? hist[n - dd - 1] : 0;
    yv = xa + (((xb - xa) * ff) >>> 8);
    wv = xin + ((yv * fb) >>> 7);
    if (wv > 32767) wv = 32767;
    if (wv < -32768) wv = -32768;
    hist.push_back(wv);
    if (yv > 32767) yv = 32767;
    if (yv < -32768) yv = -32768;
    return yv;
  endfunction

  task automatic test_reset();
    int cnt;
    bit seen;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (rdy_o !== 1'b0 || vld_o !== 1'b0 || data_o !== 16'sd0) begin
      n_bad++;
      $display("FAIL reset_hold rdy=%0b vld=%0b data=%0d required 0/0/0",
               rdy_o, vld_o, data_o);
    end
    rst = 1'b0;
    cnt = 0;
    seen = 1'b0;
    while (!rdy_o && cnt < 1100) begin
      if (vld_o !== 1'b0 || data_o !== 16'sd0) seen = 1'b1;
      cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cnt != 1024) begin
      n_bad++;
      $display("FAIL reset_clr_len got=%0d required=1024", cnt);
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL reset_outputs got=nonzero required=0");
    end
  endtask

  task automatic test_impulse();
    int y, lat, e;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      send((n == 0) ? 1000 : 0, 5 << 8, 0, y, lat);
      e = (n == 5) ? 1000 : 0;
      n_cmp++;
      if (y != e || lat != 4) begin
        n_bad++;
        $display("FAIL impulse n=%0d got=%0d lat=%0d required=%0d lat=4",
                 n, y, lat, e);
      end
    end
  endtask

  task automatic test_fraction();
    int y, lat;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      send(16 * n, (5 << 8) | 128, 0, y, lat);
      if (n >= 6) begin
        n_cmp++;
        if (y != 16 * n - 88 || lat != 4) begin
          n_bad++;
          $display("FAIL fraction n=%0d got=%0d required=%0d",
                   n, y, 16 * n - 88);
        end
      end
    end
  endtask

  task automatic test_feedback();
    int y, lat, e;
    do_reset();
    for (int n = 0; n < 18; n++) begin
      send((n == 0) ? 1000 : 0, 4 << 8, 64, y, lat);
      case (n)
        4: e = 1000;
        8: e = 500;
        12: e = 250;
        16: e = 125;
        default: e = 0;
      endcase
      n_cmp++;
      if (y != e || lat != 4) begin
        n_bad++;
        $display("FAIL feedback n=%0d got=%0d required=%0d", n, y, e);
      end
    end
  endtask

  task automatic test_saturation();
    int y, lat;
    bit bad;
    do_reset();
    bad = 1'b0;
    for (int n = 0; n < 12; n++) begin
      send(30000, 1 << 8, 127, y, lat);
      if (y < 0 || lat != 4) bad = 1'b1;
    end
    n_cmp++;
    if (bad || y != 32767) begin
      n_bad++;
      $display("FAIL sat_pos got=%0d sign_err=%0b required=32767", y, bad);
    end
    do_reset();
    bad = 1'b0;
    for (int n = 0; n < 12; n++) begin
      send(-30000, 1 << 8, 127, y, lat);
      if (y > 0 || lat != 4) bad = 1'b1;
    end
    n_cmp++;
    if (bad || y != -32768) begin
      n_bad++;
      $display("FAIL sat_neg got=%0d sign_err=%0b required=-32768", y, bad);
    end
  endtask

  task automatic test_del_min();
    int y0, y1, y2, lat;
    do_reset();
    send(1000, 0, 0, y0, lat);
    send(0, 0, 0, y1, lat);
    send(0, 128, 0, y2, lat);
    n_cmp++;
    if (y0 != 0 || y1 != 1000 || y2 != 500) begin
      n_bad++;
      $display("FAIL del_zero got=%0d,%0d,%0d required=0,1000,500",
               y0, y1, y2);
    end
  endtask

  task automatic test_del_max();
    int y, lat, other, y1022, y1023;
    do_reset();
    other = 0;
    y1022 = 0;
    y1023 = -1;
    for (int n = 0; n < 1024; n++) begin
      send((n == 0) ? 1000 : 0, 1023 << 8, 0, y, lat);
      if (n == 1022) y1022 = y;
      else if (n == 1023) y1023 = y;
      else if (y != 0 || lat != 4) other++;
    end
    n_cmp++;
    if (y1022 != 1000 || y1023 != 0) begin
      n_bad++;
      $display("FAIL del_max got=%0d,%0d required=1000,0", y1022, y1023);
    end
    n_cmp++;
    if (other != 0) begin
      n_bad++;
      $display("FAIL del_max_other got=%0d nonzero required=0", other);
    end
  endtask

  task automatic test_wrap();
    int y, lat, e, xv, dl, fb;
    do_reset();
    hist.delete();
    for (int n = 0; n < 3000; n++) begin
      xv = int'($urandom_range(40000)) - 20000;
      dl = int'($urandom_range(262143));
      fb = int'($urandom_range(128)) - 64;
      e = model(xv, dl, fb);
      send(xv, dl, fb, y, lat);
      n_cmp++;
      if (y != e || lat != 4) begin
        n_bad++;
        $display("FAIL wrap n=%0d got=%0d lat=%0d required=%0d",
                 n, y, lat, e);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int y1, y2, lat, pulses;
    do_reset();
    data_i = 16'sd1000;
    del_i = 18'(1 << 8);
    fb_i = '0;
    vld_i = 1'b1;
    @(posedge clk); #1;
    data_i = 16'sd7777;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (vld_o) pulses++;
    end
    vld_i = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (vld_o) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL busy_pulses got=%0d required=1", pulses);
    end
    send(0, 1 << 8, 0, y1, lat);
    send(0, 2 << 8, 0, y2, lat);
    n_cmp++;
    if (y1 != 1000 || y2 != 1000) begin
      n_bad++;
      $display("FAIL busy_ignore got=%0d,%0d required=1000,1000", y1, y2);
    end
  endtask

  task automatic test_rst_mul();
    int y, lat, cnt;
    bit seen;
    do_reset();
    send(1234, 1 << 8, 0, y, lat);
    send(2000, 1 << 8, 0, y, lat);
    data_i = 16'sd5000;
    del_i = 18'(1 << 8);
    fb_i = '0;
    vld_i = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (vld_o !== 1'b0 || data_o !== 16'sd0 || y != 1234) begin
      n_bad++;
      $display("FAIL rst_mul vld=%0b data=%0d prev=%0d required 0/0/1234",
               vld_o, data_o, y);
    end
    cnt = 0;
    seen = 1'b0;
    while (!rdy_o && cnt < 1100) begin
      if (vld_o) seen = 1'b1;
      cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cnt != 1024 || seen) begin
      n_bad++;
      $display("FAIL rst_mul_clr got=%0d vld_seen=%0b required=1024/0",
               cnt, seen);
    end
    send(0, 1 << 8, 0, y, lat);
    n_cmp++;
    if (y != 0 || lat != 4) begin
      n_bad++;
      $display("FAIL rst_mul_after got=%0d required=0", y);
    end
  endtask

  initial begin
    rst = 1'b1;
    vld_i = 1'b0;
    data_i = '0;
    del_i = '0;
    fb_i = '0;
    #1;
    test_reset();
    test_impulse();
    test_fraction();
    test_feedback();
    test_saturation();
    test_del_min();
    test_del_max();
    test_busy_ignore();
    test_rst_mul();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
